// File: rtl/target_crc5_pkg.sv
// Shared definitions for the HDR-DDR target CRC5 engine and its neighbours
// (deserializer, transmitter, DDR CCC engine).
package target_crc5_pkg;

    localparam int unsigned CRC_W      = 5;
    localparam int unsigned CRC_DATA_W = 8;

    localparam logic [CRC_W-1:0] CRC5_SEED = 5'h1F;
    localparam logic [CRC_W-1:0] CRC5_POLY = 5'h05;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } crc_state_e;

    // Receive-mode encodings agreed between the CCC engine, deserializer and CRC block
    localparam int unsigned RX_MODE_W = 2;
    localparam logic [RX_MODE_W-1:0] RX_MODE_DATA      = 2'd0;
    localparam logic [RX_MODE_W-1:0] RX_MODE_CCC       = 2'd1;
    localparam logic [RX_MODE_W-1:0] RX_MODE_CRC_TOKEN = 2'd2;
    localparam logic [RX_MODE_W-1:0] RX_MODE_CRC_VALUE = 2'd3;

endpackage

// File: rtl/crc5_step.sv
// Single-bit CRC5 update, G(x)=x^5+x^2+1; shared with the target transmitter.
module crc5_step
    import target_crc5_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC5_POLY
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic             data_bit,
    output logic [CRC_W-1:0] crc_out
);

    logic fb;

    always_comb begin
        fb      = crc_in[CRC_W-1] ^ data_bit;
        crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : CRC_W'(0));
    end

endmodule

// File: rtl/target_crc5.sv
// Bit-serial CRC5 engine folding deserialized bytes (MSB first) into a running CRC.
module target_crc5
    import target_crc5_pkg::*;
#(
    parameter logic [CRC_W-1:0] SEED   = CRC5_SEED,
    parameter logic [CRC_W-1:0] POLY   = CRC5_POLY,
    parameter int unsigned      DATA_W = CRC_DATA_W
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_crc_en,
    input  logic              i_crc_init,
    input  logic              i_crc_data_valid,
    input  logic [DATA_W-1:0] i_crc_data_in,
    output logic [CRC_W-1:0]  o_crc_value,
    output logic              o_crc_busy,
    output logic              o_crc_done,
    output logic              o_crc_overrun,
    output logic [7:0]        o_crc_byte_cnt
);

    localparam int unsigned CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned BYTE_CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    crc_state_e            state_q, state_d;
    logic [CRC_W-1:0]      crc_q, crc_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;
    logic [CRC_W-1:0]      crc_next;

    crc5_step #(.POLY(POLY)) u_step (
        .crc_in   (crc_q),
        .data_bit (shift_q[DATA_W-1]),
        .crc_out  (crc_next)
    );

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) begin
            state_q    <= ST_IDLE;
            crc_q      <= SEED;
            shift_q    <= '0;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    // Init wins over everything, even with the engine disabled
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        overrun_d  = overrun_q;
        done_d     = 1'b0;

        if (i_crc_init) begin
            state_d    = ST_IDLE;
            crc_d      = SEED;
            cnt_d      = '0;
            byte_cnt_d = '0;
            overrun_d  = 1'b0;
        end else if (i_crc_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_crc_data_valid) begin
                        shift_d = i_crc_data_in;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    crc_d   = crc_next;
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    if (i_crc_data_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (cnt_q == LAST_BIT) begin
                        state_d    = ST_IDLE;
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        done_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_SHIFT);
    end

    assign o_crc_value    = crc_q;
    assign o_crc_busy     = busy_q;
    assign o_crc_done     = done_q;
    assign o_crc_overrun  = overrun_q;
    assign o_crc_byte_cnt = byte_cnt_q;

endmodule
